// File: rtl/ws_array_ctrl_if.sv
// ---------------------------------------------------------------------------
// ws_array_ctrl_if
//   Bundles the job/host handshake and the PE-array enable lines of the
//   weight-stationary array sequencer.
//
//   Signals
//     start        host -> ctrl  job request (sampled only in IDLE)
//     abort        host -> ctrl  cancel the running job
//     num_vec      host -> ctrl  vectors in the job, sampled with start
//     busy         ctrl -> host  high while loading weights / computing
//     done         ctrl -> host  one-cycle pulse at job end
//     w_row_sel    ctrl -> array one-hot weight-row load select
//     w_rd_addr    ctrl -> wbuf  weight buffer row address
//     enable_w     ctrl -> array weight load enable (= |w_row_sel)
//     enable_in    ctrl -> array per-row skewed ifmap enable
//     enable_sum   ctrl -> array psum accumulate enable
//     out_valid    ctrl -> host  per-column result valid
//     perf_cycles  ctrl -> host  busy-cycle counter (WS_CTRL_PERF_EN only)
//
//   Modports: master = host/array side, slave = controller.
// ---------------------------------------------------------------------------
interface ws_array_ctrl_if #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int VEC_W = 8
);
    logic                      start;
    logic                      abort;
    logic [VEC_W-1:0]          num_vec;
    logic                      busy;
    logic                      done;
    logic [ROWS-1:0]           w_row_sel;
    logic [$clog2(ROWS)-1:0]   w_rd_addr;
    logic                      enable_w;
    logic [ROWS-1:0]           enable_in;
    logic                      enable_sum;
    logic [COLS-1:0]           out_valid;
`ifdef WS_CTRL_PERF_EN
    logic [31:0]               perf_cycles;
`endif

    modport master (
        output start, abort, num_vec,
        input  busy, done, w_row_sel, w_rd_addr, enable_w,
               enable_in, enable_sum, out_valid
`ifdef WS_CTRL_PERF_EN
        , input perf_cycles
`endif
    );

    modport slave (
        input  start, abort, num_vec,
        output busy, done, w_row_sel, w_rd_addr, enable_w,
               enable_in, enable_sum, out_valid
`ifdef WS_CTRL_PERF_EN
        , output perf_cycles
`endif
    );
endinterface

// File: rtl/ws_array_ctrl.sv
// ---------------------------------------------------------------------------
// ws_array_ctrl
//   Job sequencer for a ROWS x COLS weight-stationary PE array. A job loads
//   one weight row per cycle (LOAD_W), then streams num_vec input vectors
//   with a one-cycle skew per row while holding the psum enable through
//   fill and drain (COMPUTE), then pulses done for one cycle (DONE).
//
//   Ports
//     iClk     clock, rising edge
//     iRest_n  asynchronous active-low reset
//     bus      ws_array_ctrl_if.slave (handshake + array enables)
//
//   Every output is a flop. Next-cycle output values are decoded from the
//   next state/counter, so the outputs line up with the state they describe.
//
//   Optional feature: define WS_CTRL_PERF_EN to add bus.perf_cycles, a
//   saturating count of busy cycles for the last accepted job.
// ---------------------------------------------------------------------------
module ws_array_ctrl #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int VEC_W   = 8,
    parameter int OUT_LAT = 1
) (
    input  logic               iClk,
    input  logic               iRest_n,
    ws_array_ctrl_if.slave     bus
);

    localparam int AW    = $clog2(ROWS);
    // Longest COMPUTE phase; counter and all window bounds fit below it.
    localparam int T_MAX = (1 << VEC_W) - 1 + (ROWS - 1) + (COLS - 1) + OUT_LAT;
    localparam int CNT_W = $clog2(T_MAX + 1);
    // Last COMPUTE index is num_vec + TAIL.
    localparam int TAIL  = (ROWS - 1) + (COLS - 1) + OUT_LAT - 1;
    // First t at which column 0 holds a finished result.
    localparam int D     = ROWS - 1 + OUT_LAT;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_W,
        S_COMPUTE,
        S_DONE
    } state_e;

    typedef struct packed {
        logic            busy;
        logic            done;
        logic            enable_w;
        logic            enable_sum;
        logic [ROWS-1:0] w_row_sel;
        logic [AW-1:0]   w_rd_addr;
        logic [ROWS-1:0] enable_in;
        logic [COLS-1:0] out_valid;
    } outs_t;

    state_e           state_q, state_d;
    cnt_t             cnt_q, cnt_d;      // row index in LOAD_W, t in COMPUTE
    logic [VEC_W-1:0] nv_q, nv_d;        // latched num_vec
    outs_t            out_q, out_d;
    logic             accept;
    cnt_t             t_last;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nv_d    = nv_q;
        accept  = 1'b0;
        t_last  = cnt_t'(nv_q) + cnt_t'(TAIL);

        unique case (state_q)
            S_IDLE: begin
                // A zero-length job is dropped; abort wins over start.
                if (bus.start && !bus.abort && (bus.num_vec != '0)) begin
                    accept  = 1'b1;
                    nv_d    = bus.num_vec;
                    cnt_d   = '0;
                    state_d = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == cnt_t'(ROWS - 1)) begin
                    state_d = S_COMPUTE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_COMPUTE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == t_last) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Output decode from the next state, registered below
    // ---------------------------------------------------------------------
    always_comb begin
        out_d = '0;
        unique case (state_d)
            S_LOAD_W: begin
                out_d.busy      = 1'b1;
                out_d.enable_w  = 1'b1;
                out_d.w_row_sel = {{(ROWS-1){1'b0}}, 1'b1} << cnt_d;
                out_d.w_rd_addr = cnt_d[AW-1:0];
            end
            S_COMPUTE: begin
                out_d.busy       = 1'b1;
                out_d.enable_sum = 1'b1;
                // Row r consumes vector t-r: window [r, r+num_vec).
                for (int r = 0; r < ROWS; r++) begin
                    out_d.enable_in[r] = (cnt_d >= cnt_t'(r)) &&
                                         (cnt_d <  cnt_t'(r) + cnt_t'(nv_d));
                end
                // Column c drains D+c cycles after its first vector entered.
                for (int c = 0; c < COLS; c++) begin
                    out_d.out_valid[c] = (cnt_d >= cnt_t'(D + c)) &&
                                         (cnt_d <  cnt_t'(D + c) + cnt_t'(nv_d));
                end
            end
            S_DONE: begin
                out_d.done = 1'b1;
            end
            default: begin
                out_d = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge iClk or negedge iRest_n) begin
        if (!iRest_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            nv_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nv_q    <= nv_d;
            out_q   <= out_d;
        end
    end

    assign bus.busy       = out_q.busy;
    assign bus.done       = out_q.done;
    assign bus.enable_w   = out_q.enable_w;
    assign bus.enable_sum = out_q.enable_sum;
    assign bus.w_row_sel  = out_q.w_row_sel;
    assign bus.w_rd_addr  = out_q.w_rd_addr;
    assign bus.enable_in  = out_q.enable_in;
    assign bus.out_valid  = out_q.out_valid;

`ifdef WS_CTRL_PERF_EN
    // ---------------------------------------------------------------------
    // Busy-cycle counter: counts cycles in which busy is shown, so the
    // value seen in the DONE cycle covers the whole job. Holds afterwards.
    // ---------------------------------------------------------------------
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (accept) begin
            perf_d = '0;
        end else if (out_q.busy && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge iClk or negedge iRest_n) begin
        if (!iRest_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign bus.perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_ws_array_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ws_array_ctrl
//   Directed bench for ws_array_ctrl with ROWS=COLS=4, VEC_W=8, OUT_LAT=1.
//   Outputs are packed into one vector and compared #1 after each rising
//   edge against hand-written expectations. "cycle k" means the k-th cycle
//   after the edge that accepted start.
// ---------------------------------------------------------------------------
module tb_ws_array_ctrl;

    logic iClk    = 1'b0;
    logic iRest_n = 1'b0;

    ws_array_ctrl_if #(.ROWS(4), .COLS(4), .VEC_W(8)) bus ();

    ws_array_ctrl #(
        .ROWS    (4),
        .COLS    (4),
        .VEC_W   (8),
        .OUT_LAT (1)
    ) dut (
        .iClk    (iClk),
        .iRest_n (iRest_n),
        .bus     (bus)
    );

    always #5 iClk = ~iClk;

    int total = 0;
    int bad   = 0;

    // {busy, done, enable_w, enable_sum, w_row_sel, w_rd_addr, enable_in, out_valid}
    logic [17:0] obs;
    assign obs = {bus.busy, bus.done, bus.enable_w, bus.enable_sum,
                  bus.w_row_sel, bus.w_rd_addr, bus.enable_in, bus.out_valid};

    // num_vec=3 COMPUTE windows, indexed by t=0..9 (worked out by hand).
    localparam logic [3:0] EXP_IN [10] = '{4'b0001, 4'b0011, 4'b0111, 4'b1110,
                                           4'b1100, 4'b1000, 4'b0000, 4'b0000,
                                           4'b0000, 4'b0000};
    localparam logic [3:0] EXP_OV [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                           4'b0001, 4'b0011, 4'b0111, 4'b1110,
                                           4'b1100, 4'b1000};

    function automatic logic [17:0] mk(input logic b, input logic d,
                                       input logic ew, input logic es,
                                       input logic [3:0] sel, input logic [1:0] addr,
                                       input logic [3:0] ein, input logic [3:0] ov);
        return {b, d, ew, es, sel, addr, ein, ov};
    endfunction

    // Expected outputs for cycle k of a num_vec=3 job.
    function automatic logic [17:0] exp3(input int k);
        logic [17:0] v;
        v = '0;
        case (k)
            1:  v = mk(1, 0, 1, 0, 4'b0001, 2'd0, 4'b0, 4'b0);
            2:  v = mk(1, 0, 1, 0, 4'b0010, 2'd1, 4'b0, 4'b0);
            3:  v = mk(1, 0, 1, 0, 4'b0100, 2'd2, 4'b0, 4'b0);
            4:  v = mk(1, 0, 1, 0, 4'b1000, 2'd3, 4'b0, 4'b0);
            15: v = mk(0, 1, 0, 0, 4'b0000, 2'd0, 4'b0, 4'b0);
            default: begin
                if (k >= 5 && k <= 14)
                    v = mk(1, 0, 0, 1, 4'b0000, 2'd0, EXP_IN[k-5], EXP_OV[k-5]);
            end
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Full num_vec=3 job; optional start re-pulse during COMPUTE t=2.
    task automatic run_job3(input string tag, input bit repulse);
        bus.start   = 1'b1;
        bus.num_vec = 8'd3;
        tick();
        bus.start   = 1'b0;
        bus.num_vec = 8'd9;          // mid-job change must be ignored
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("%s_c%0d", tag, k), 32'(obs), 32'(exp3(k)));
`ifdef WS_CTRL_PERF_EN
            if (k == 15) check($sformatf("%s_perf", tag), bus.perf_cycles, 32'd14);
`endif
            bus.start = repulse && (k == 7);
            if (k == 7) bus.num_vec = 8'd5;
            tick();
        end
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.num_vec = '0;

        // Reset state
        #2;
        check("reset_outs", 32'(obs), 32'd0);
`ifdef WS_CTRL_PERF_EN
        check("reset_perf", bus.perf_cycles, 32'd0);
`endif
        @(negedge iClk);
        iRest_n = 1'b1;
        tick();
        check("idle_after_reset", 32'(obs), 32'd0);

        // Nominal num_vec=3 job
        run_job3("job3", 1'b0);

        // Zero-length job is ignored
        bus.start   = 1'b1;
        bus.num_vec = 8'd0;
        tick();
        bus.start   = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("nv0_c%0d", k), 32'(obs), 32'd0);
            tick();
        end

        // Start re-pulsed during COMPUTE is ignored
        run_job3("repulse", 1'b1);

        // Abort at COMPUTE t=5 (cycle 10)
        bus.start   = 1'b1;
        bus.num_vec = 8'd3;
        tick();
        bus.start   = 1'b0;
        repeat (9) tick();
        check("abort_pre_t5", 32'(obs), 32'(exp3(10)));
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_idle", 32'(obs), 32'd0);
`ifdef WS_CTRL_PERF_EN
        check("abort_perf_kept", bus.perf_cycles, 32'd10);
`endif
        tick();
        check("abort_no_done1", 32'(obs), 32'd0);
        tick();
        check("abort_no_done2", 32'(obs), 32'd0);

        // New job after abort, num_vec=1: T=8, done at cycle 13
        bus.start   = 1'b1;
        bus.num_vec = 8'd1;
        tick();
        bus.start   = 1'b0;
        check("nv1_c1", 32'(obs), 32'(mk(1, 0, 1, 0, 4'b0001, 2'd0, 4'b0000, 4'b0000)));
`ifdef WS_CTRL_PERF_EN
        check("nv1_perf_clr", bus.perf_cycles, 32'd0);
`endif
        repeat (4) tick();
        check("nv1_c5",  32'(obs), 32'(mk(1, 0, 0, 1, 4'b0000, 2'd0, 4'b0001, 4'b0000)));
        repeat (3) tick();
        check("nv1_c8",  32'(obs), 32'(mk(1, 0, 0, 1, 4'b0000, 2'd0, 4'b1000, 4'b0000)));
        tick();
        check("nv1_c9",  32'(obs), 32'(mk(1, 0, 0, 1, 4'b0000, 2'd0, 4'b0000, 4'b0001)));
        repeat (3) tick();
        check("nv1_c12", 32'(obs), 32'(mk(1, 0, 0, 1, 4'b0000, 2'd0, 4'b0000, 4'b1000)));
        tick();
        check("nv1_c13", 32'(obs), 32'(mk(0, 1, 0, 0, 4'b0000, 2'd0, 4'b0000, 4'b0000)));
        tick();
        check("nv1_c14", 32'(obs), 32'd0);

        // Asynchronous reset mid-COMPUTE (cycle 8, t=3)
        bus.start   = 1'b1;
        bus.num_vec = 8'd3;
        tick();
        bus.start   = 1'b0;
        repeat (7) tick();
        check("rst_pre", 32'(obs), 32'(exp3(8)));
        #2;
        iRest_n = 1'b0;
        #1;
        check("rst_async_outs", 32'(obs), 32'd0);
        @(negedge iClk);
        iRest_n = 1'b1;
        tick();
        check("rst_release_idle", 32'(obs), 32'd0);
        tick();
        check("rst_no_done", 32'(obs), 32'd0);

        // Job accepted again after reset
        run_job3("post_rst", 1'b0);

`ifdef WS_CTRL_PERF_EN
        // Longest job: 4 load + 262 compute busy cycles
        bus.start   = 1'b1;
        bus.num_vec = 8'd255;
        tick();
        bus.start   = 1'b0;
        repeat (266) tick();
        check("nv255_done", 32'(obs), 32'(mk(0, 1, 0, 0, 4'b0000, 2'd0, 4'b0000, 4'b0000)));
        check("nv255_perf", bus.perf_cycles, 32'd266);
        tick();
        check("nv255_perf_hold", bus.perf_cycles, 32'd266);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
